// File: rtl/instr_cache_ctrl.sv
// Tag/valid owner and miss-refill controller for a direct-mapped instruction cache.
// Optional hit/miss performance counters are built when ICACHE_PERF_EN is defined.
module instr_cache_ctrl #(
  parameter int TAG_W    = 21,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cpu_req_i,
  input  logic [29:0]         cpu_addr_i,
  output logic                cpu_hit_o,
  output logic                cpu_stall_o,
  input  logic                flush_i,
  output logic                mem_req_o,
  output logic [29:0]         mem_addr_o,
  input  logic                mem_ack_i,
  input  logic [31:0]         mem_data_i,
  output logic                fill_we_o,
  output logic [INDEX_W-1:0]  fill_index_o,
  output logic [OFFSET_W-1:0] fill_offset_o,
  output logic [31:0]         fill_data_o
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o
`endif
);

  localparam int LINES = 1 << INDEX_W;
  localparam logic [OFFSET_W-1:0] LAST_WORD = '1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REFILL = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_arr [LINES];
  logic [TAG_W-1:0]    miss_tag_q;
  logic [INDEX_W-1:0]  miss_index_q;
  logic [OFFSET_W-1:0] counter_q;
  logic                flush_pend_q;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic                unused_offset;
  logic                in_idle, lookup_hit, miss, refill_ack;

  assign req_tag       = cpu_addr_i[OFFSET_W+INDEX_W +: TAG_W];
  assign req_index     = cpu_addr_i[OFFSET_W +: INDEX_W];
  assign unused_offset = ^cpu_addr_i[OFFSET_W-1:0];

  assign in_idle    = (state_q == IDLE);
  assign lookup_hit = valid_q[req_index] && (tag_arr[req_index] == req_tag);
  assign miss       = in_idle && cpu_req_i && !lookup_hit;
  assign refill_ack = (state_q == REFILL) && mem_ack_i;

  assign cpu_hit_o   = in_idle && cpu_req_i && lookup_hit;
  assign cpu_stall_o = in_idle ? (cpu_req_i && !lookup_hit) : 1'b1;

  assign mem_req_o  = (state_q == REFILL);
  assign mem_addr_o = {miss_tag_q, miss_index_q, counter_q};

  // The fill port is forced to zero outside acknowledged refill cycles.
  assign fill_we_o     = refill_ack;
  assign fill_index_o  = refill_ack ? miss_index_q : '0;
  assign fill_offset_o = refill_ack ? counter_q : '0;
  assign fill_data_o   = refill_ack ? mem_data_i : '0;

  // NOTE: combinational blocks assign a default first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss) state_d = REFILL;
      REFILL:  if (refill_ack && counter_q == LAST_WORD) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
      counter_q    <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (flush_i) valid_q <= '0;
          if (miss) begin
            miss_tag_q   <= req_tag;
            miss_index_q <= req_index;
            counter_q    <= '0;
          end
        end
        REFILL: begin
          if (flush_i) flush_pend_q <= 1'b1;
          if (refill_ack) counter_q <= counter_q + 1'b1;
        end
        UPDATE: begin
          // A flush seen during the refill wins over validating the new line.
          if (flush_pend_q || flush_i) valid_q <= '0;
          else                         valid_q[miss_index_q] <= 1'b1;
          flush_pend_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the tag array is storage, not control; valid bits gate it, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (state_q == UPDATE) tag_arr[miss_index_q] <= miss_tag_q;
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (cpu_hit_o && hit_cnt_o != 32'hFFFF_FFFF) hit_cnt_o <= hit_cnt_o + 32'd1;
      if (miss && miss_cnt_o != 32'hFFFF_FFFF)     miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_cache_ctrl.sv
// Scoreboard bench for instr_cache_ctrl: expected fill beats are queued per miss and
// popped as the controller writes them; a small tag/valid model predicts hit or miss.
module tb_instr_cache_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cpu_req_i;
  logic [29:0] cpu_addr_i;
  logic        cpu_hit_o, cpu_stall_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [29:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        fill_we_o;
  logic [3:0]  fill_index_o;
  logic [4:0]  fill_offset_o;
  logic [31:0] fill_data_o;

  instr_cache_ctrl dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cpu_req_i    (cpu_req_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_hit_o    (cpu_hit_o),
    .cpu_stall_o  (cpu_stall_o),
    .flush_i      (flush_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i),
    .fill_we_o    (fill_we_o),
    .fill_index_o (fill_index_o),
    .fill_offset_o(fill_offset_o),
    .fill_data_o  (fill_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory returns a data pattern derived from the requested word address.
  assign mem_data_i = {mem_addr_o, 2'b00} ^ 32'hDEAD_BEEF;

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  idx;
    logic [4:0]  off;
    logic [31:0] data;
  } fill_t;

  fill_t       sb[$];
  bit          mval[16];
  logic [20:0] mtag[16];
  int          checks = 0;
  int          failures = 0;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mval[i] = 1'b0;
  endtask

  // One fetch of a byte address; the model decides hit or miss and the expected stall length.
  task automatic fetch(input logic [31:0] baddr, input int period, input int flush_word);
    logic [29:0] w;
    logic [3:0]  idx;
    logic [20:0] tag;
    bit          miss, flushed;
    int          exp_stalls, acks, rc;
    fill_t       e;
    w   = baddr[31:2];
    idx = w[8:5];
    tag = w[29:9];
    miss = !(mval[idx] && mtag[idx] == tag);
    @(posedge clk_i); #1;
    cpu_req_i  = 1'b1;
    cpu_addr_i = w;
    if (!miss) begin
      @(negedge clk_i);
      checks++; if (cpu_hit_o !== 1'b1) begin failures++; $display("FAIL hit_flag addr=%h act=%b exp=1", baddr, cpu_hit_o); end
      checks++; if (cpu_stall_o !== 1'b0) begin failures++; $display("FAIL hit_stall addr=%h act=%b exp=0", baddr, cpu_stall_o); end
      checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL hit_memreq addr=%h act=%b exp=0", baddr, mem_req_o); end
      checks++; if (fill_we_o !== 1'b0) begin failures++; $display("FAIL hit_fillwe addr=%h act=%b exp=0", baddr, fill_we_o); end
    end else begin
      for (int o = 0; o < 32; o++) begin
        e.addr = {tag, idx, o[4:0]};
        e.idx  = idx;
        e.off  = o[4:0];
        e.data = {e.addr, 2'b00} ^ 32'hDEAD_BEEF;
        sb.push_back(e);
      end
      exp_stalls = 2 + 32 * period;
      acks = 0; rc = 0; flushed = 1'b0;
      for (int n = 1; n <= exp_stalls; n++) begin
        @(negedge clk_i);
        flush_i   = 1'b0;
        mem_ack_i = 1'b0;
        checks++; if (cpu_stall_o !== 1'b1) begin failures++; $display("FAIL miss_stall addr=%h cycle=%0d act=%b exp=1", baddr, n, cpu_stall_o); end
        if (n == 1 || n == exp_stalls) begin
          if (n == 1) begin
            checks++; if (cpu_hit_o !== 1'b0) begin failures++; $display("FAIL miss_hitflag addr=%h act=%b exp=0", baddr, cpu_hit_o); end
          end
          checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL memreq_outside addr=%h cycle=%0d act=%b exp=0", baddr, n, mem_req_o); end
          #1;
          checks++; if (fill_we_o !== 1'b0) begin failures++; $display("FAIL fillwe_outside addr=%h cycle=%0d act=%b exp=0", baddr, n, fill_we_o); end
        end else begin
          checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL memreq_refill addr=%h cycle=%0d act=%b exp=1", baddr, n, mem_req_o); end
          rc++;
          if (!flushed && flush_word >= 0 && acks == flush_word) begin
            flush_i = 1'b1;
            flushed = 1'b1;
          end
          mem_ack_i = (rc % period == 0);
          #1;
          if (sb.size() == 0) begin
            checks++; failures++; $display("FAIL sb_underflow addr=%h cycle=%0d act=empty exp=entry", baddr, n);
          end else begin
            checks++; if (mem_addr_o !== sb[0].addr) begin failures++; $display("FAIL mem_addr cycle=%0d act=%h exp=%h", n, mem_addr_o, sb[0].addr); end
            if (mem_ack_i) begin
              e = sb.pop_front();
              acks++;
              checks++; if (fill_we_o !== 1'b1) begin failures++; $display("FAIL fill_we_ack act=%b exp=1", fill_we_o); end
              checks++; if (fill_index_o !== e.idx) begin failures++; $display("FAIL fill_index act=%h exp=%h", fill_index_o, e.idx); end
              checks++; if (fill_offset_o !== e.off) begin failures++; $display("FAIL fill_offset act=%h exp=%h", fill_offset_o, e.off); end
              checks++; if (fill_data_o !== e.data) begin failures++; $display("FAIL fill_data act=%h exp=%h", fill_data_o, e.data); end
            end else begin
              checks++; if (fill_we_o !== 1'b0) begin failures++; $display("FAIL fill_we_noack cycle=%0d act=%b exp=0", n, fill_we_o); end
            end
          end
        end
      end
      flush_i   = 1'b0;
      mem_ack_i = 1'b0;
      mtag[idx] = tag;
      if (flushed) model_clear();
      else begin
        mval[idx] = 1'b1;
        @(negedge clk_i);
        checks++; if (cpu_hit_o !== 1'b1) begin failures++; $display("FAIL replay_hit addr=%h act=%b exp=1", baddr, cpu_hit_o); end
        checks++; if (cpu_stall_o !== 1'b0) begin failures++; $display("FAIL replay_stall addr=%h act=%b exp=0", baddr, cpu_stall_o); end
      end
    end
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0;
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover addr=%h act=%0d exp=0", baddr, sb.size()); end
    sb.delete();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; cpu_req_i = 1'b0; cpu_addr_i = '0; flush_i = 1'b0; mem_ack_i = 1'b0;
    model_clear();
    repeat (3) @(negedge clk_i);
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL rst_memreq act=%b exp=0", mem_req_o); end
    checks++; if (fill_we_o !== 1'b0) begin failures++; $display("FAIL rst_fillwe act=%b exp=0", fill_we_o); end
    checks++; if (cpu_hit_o !== 1'b0) begin failures++; $display("FAIL rst_hit act=%b exp=0", cpu_hit_o); end
    checks++; if (cpu_stall_o !== 1'b0) begin failures++; $display("FAIL rst_stall act=%b exp=0", cpu_stall_o); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_cold_miss_and_hit();
    fetch(32'h0000_0880, 1, -1);
    fetch(32'h0000_08FC, 1, -1);
  endtask

  task automatic test_conflict();
    fetch(32'h0000_1080, 1, -1);
    fetch(32'h0000_0880, 1, -1);
    fetch(32'h8000_0880, 1, -1);
    fetch(32'h0000_0880, 1, -1);
  endtask

  task automatic test_slow_mem();
    fetch(32'h0000_0100, 3, -1);
    fetch(32'h0000_0104, 1, -1);
  endtask

  task automatic test_flush_refill();
    fetch(32'h0000_0180, 1, 10);
    fetch(32'h0000_0180, 1, -1);
  endtask

  task automatic test_flush_idle();
    fetch(32'h0000_0880, 1, -1);
    @(posedge clk_i); #1;
    cpu_req_i  = 1'b1;
    cpu_addr_i = 30'h0000_0880 >> 2;
    flush_i    = 1'b1;
    @(negedge clk_i);
    checks++; if (cpu_hit_o !== 1'b1) begin failures++; $display("FAIL flush_same_cycle_hit act=%b exp=1", cpu_hit_o); end
    checks++; if (cpu_stall_o !== 1'b0) begin failures++; $display("FAIL flush_same_cycle_stall act=%b exp=0", cpu_stall_o); end
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0;
    flush_i   = 1'b0;
    model_clear();
    fetch(32'h0000_0880, 1, -1);
    fetch(32'h0000_0180, 1, -1);
  endtask

  task automatic test_reset_mid_refill();
    @(posedge clk_i); #1;
    cpu_req_i  = 1'b1;
    cpu_addr_i = 30'h0000_3300 >> 2;
    mem_ack_i  = 1'b1;
    repeat (7) @(negedge clk_i);
    checks++; if (fill_offset_o !== 5'd5) begin failures++; $display("FAIL prereset_offset act=%0d exp=5", fill_offset_o); end
    rst_ni = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL midrst_memreq act=%b exp=0", mem_req_o); end
    checks++; if (fill_we_o !== 1'b0) begin failures++; $display("FAIL midrst_fillwe act=%b exp=0", fill_we_o); end
    @(posedge clk_i); #1;
    rst_ni    = 1'b1;
    cpu_req_i = 1'b0;
    mem_ack_i = 1'b0;
    model_clear();
    fetch(32'h0000_3300, 1, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      cpu_req_i  = 1'b1;
      cpu_addr_i = (30'h0000_3300 >> 2) + 30'(i * 7);
      @(negedge clk_i);
      checks++; if (cpu_hit_o !== 1'b1) begin failures++; $display("FAIL b2b_hit i=%0d act=%b exp=1", i, cpu_hit_o); end
      checks++; if (cpu_stall_o !== 1'b0) begin failures++; $display("FAIL b2b_stall i=%0d act=%b exp=0", i, cpu_stall_o); end
    end
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss_and_hit();
    test_conflict();
    test_slow_mem();
    test_flush_refill();
    test_flush_idle();
    test_reset_mid_refill();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
